// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values, payout FSM states,
// and the denomination index type used by acceptance and payout.
package vend_pkg;

    // Coin values, shared with the coin-acceptance logic.
    localparam int AMT_W_DEF       = 7;
    localparam int COIN0_VAL       = 1;
    localparam int COIN1_VAL       = 5;
    localparam int COIN2_VAL       = 10;
    localparam int COIN3_VAL       = 20;
    localparam int ACK_TIMEOUT_DEF = 255;

    typedef logic [1:0] coin_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_REQ    = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational priority picker: largest available coin <= remaining.
// Ports: remaining, empty[3:0] in; sel (index), none (nothing fits) out.
module coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = AMT_W_DEF,
    parameter int COIN0 = COIN0_VAL,
    parameter int COIN1 = COIN1_VAL,
    parameter int COIN2 = COIN2_VAL,
    parameter int COIN3 = COIN3_VAL
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [3:0]       empty,
    output coin_idx_t        sel,
    output logic             none
);

    always_comb begin
        sel  = 2'd0;
        none = 1'b0;
        if (!empty[3] && (AMT_W'(COIN3) <= remaining)) begin
            sel = 2'd3;
        end else if (!empty[2] && (AMT_W'(COIN2) <= remaining)) begin
            sel = 2'd2;
        end else if (!empty[1] && (AMT_W'(COIN1) <= remaining)) begin
            sel = 2'd1;
        end else if (!empty[0] && (AMT_W'(COIN0) <= remaining)) begin
            sel = 2'd0;
        end else begin
            none = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a balance as coins, largest first, one req/ack per coin.
// Ports: clk, rst (sync, active-low), start/amount, empty, coin_ack,
// clear in; coin_req/coin_sel, busy, done, fault, remaining,
// coins_paid out (all registered).
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = AMT_W_DEF,
    parameter int COIN0       = COIN0_VAL,
    parameter int COIN1       = COIN1_VAL,
    parameter int COIN2       = COIN2_VAL,
    parameter int COIN3       = COIN3_VAL,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic [3:0]       empty,
    input  logic             coin_ack,
    input  logic             clear,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [AMT_W-1:0] coins_paid
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic             coin_req_q, coin_req_d;
    coin_idx_t        coin_sel_q, coin_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [AMT_W-1:0] coins_paid_q, coins_paid_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    coin_idx_t        pick_sel;
    logic             pick_none;
    logic [AMT_W-1:0] sel_val;

    coin_select #(
        .AMT_W (AMT_W),
        .COIN0 (COIN0),
        .COIN1 (COIN1),
        .COIN2 (COIN2),
        .COIN3 (COIN3)
    ) u_pick (
        .remaining (remaining_q),
        .empty     (empty),
        .sel       (pick_sel),
        .none      (pick_none)
    );

    always_comb begin
        unique case (coin_sel_q)
            2'd0:    sel_val = AMT_W'(COIN0);
            2'd1:    sel_val = AMT_W'(COIN1);
            2'd2:    sel_val = AMT_W'(COIN2);
            default: sel_val = AMT_W'(COIN3);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        coin_req_d   = coin_req_q;
        coin_sel_d   = coin_sel_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fault_d      = fault_q;
        remaining_d  = remaining_q;
        coins_paid_d = coins_paid_q;
        tmo_d        = tmo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    coins_paid_d = '0;
                    busy_d       = 1'b1;
                    if (amount != '0) begin
                        remaining_d = amount;
                        state_d     = ST_SELECT;
                    end else begin
                        remaining_d = '0;
                        state_d     = ST_DONE;
                    end
                end
            end

            ST_SELECT: begin
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else if (pick_none) begin
                    fault_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FAULT;
                end else begin
                    coin_sel_d = pick_sel;
                    coin_req_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = ST_REQ;
                end
            end

            ST_REQ: begin
                if (coin_ack) begin
                    coin_req_d  = 1'b0;
                    // Picker guaranteed sel_val <= remaining.
                    remaining_d = remaining_q - sel_val;
                    if (coins_paid_q != '1) begin
                        coins_paid_d = coins_paid_q + 1'b1;
                    end
                    state_d = ST_GAP;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    // Final REQ cycle: request has been up ACK_TIMEOUT cycles.
                    coin_req_d = 1'b0;
                    fault_d    = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_GAP: begin
                state_d = ST_SELECT;
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            ST_FAULT: begin
                if (clear) begin
                    fault_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            coin_req_q   <= 1'b0;
            coin_sel_q   <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            remaining_q  <= '0;
            coins_paid_q <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            coin_req_q   <= coin_req_d;
            coin_sel_q   <= coin_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            remaining_q  <= remaining_d;
            coins_paid_q <= coins_paid_d;
            tmo_q        <= tmo_d;
        end
    end

    assign coin_req   = coin_req_q;
    assign coin_sel   = coin_sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign remaining  = remaining_q;
    assign coins_paid = coins_paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a small hopper responder.
// Checks coin order, handshake spacing, timeout, fault/clear and reset.
module tb_change_dispenser;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] amount;
    logic [3:0] empty;
    logic       coin_ack;
    logic       clear;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic       fault;
    logic [6:0] remaining;
    logic [6:0] coins_paid;

    int n_chk = 0;
    int n_err = 0;

    int sels[$];
    int n_done;
    int n_fault;
    int req_total;
    int gap_bad;
    int busy_cyc;
    int done_cyc;
    int ended;

    change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .amount     (amount),
        .empty      (empty),
        .coin_ack   (coin_ack),
        .clear      (clear),
        .coin_req   (coin_req),
        .coin_sel   (coin_sel),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .remaining  (remaining),
        .coins_paid (coins_paid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_seq(input string tag, input int exp[$]);
        check({tag, "_len"}, sels.size(), exp.size());
        for (int i = 0; i < exp.size() && i < sels.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), sels[i], exp[i]);
        end
    endtask

    // Start a payout and act as the hopper: ack ack_dly cycles after a
    // request is seen (never if ack_dly < 0). Stops on done, fault,
    // after stop_req request rises (if > 0), or when budget runs out.
    task automatic run_pay(input logic [6:0] amt, input logic [3:0] emp,
                           input int ack_dly, input int budget,
                           input int stop_req);
        int  req_cnt;
        int  gap_len;
        logic prev_req;
        sels.delete();
        n_done    = 0;
        n_fault   = 0;
        req_total = 0;
        gap_bad   = 0;
        busy_cyc  = 0;
        done_cyc  = -1;
        ended     = 0;
        req_cnt   = 0;
        gap_len   = 0;
        prev_req  = 1'b0;
        amount    = amt;
        empty     = emp;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy) busy_cyc++;
            if (coin_req) begin
                req_cnt++;
                req_total++;
                if (!prev_req) begin
                    sels.push_back(int'(coin_sel));
                    if (sels.size() > 1 && gap_len < 1) gap_bad++;
                end
                gap_len  = 0;
                coin_ack = (ack_dly >= 0 && req_cnt == ack_dly);
            end else begin
                req_cnt  = 0;
                gap_len++;
                coin_ack = 1'b0;
            end
            prev_req = coin_req;
            if (done) begin
                n_done++;
                done_cyc = i;
                ended    = 1;
                break;
            end
            if (fault) begin
                n_fault++;
                ended = 1;
                break;
            end
            if (stop_req > 0 && sels.size() == stop_req) begin
                ended = 1;
                break;
            end
            tick();
        end
        coin_ack = 1'b0;
        check("run_ended", ended, 1);
    endtask

    initial begin
        int exp_q[$];
        rst      = 1'b0;
        start    = 1'b0;
        amount   = '0;
        empty    = '0;
        coin_ack = 1'b0;
        clear    = 1'b0;
        tick();
        tick();
        check("rst_req", coin_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_rem", remaining, 0);
        check("rst_paid", coins_paid, 0);
        rst = 1'b1;
        tick();

        // 38 = 20 + 10 + 5 + 1 + 1 + 1
        run_pay(7'd38, 4'b0000, 2, 200, 0);
        exp_q = '{3, 2, 1, 0, 0, 0};
        check_seq("p38_sel", exp_q);
        check("p38_paid", coins_paid, 6);
        check("p38_rem", remaining, 0);
        check("p38_done", n_done, 1);
        check("p38_gap", gap_bad, 0);
        check("p38_busy_end", busy, 0);
        tick();
        check("p38_done_pulse", done, 0);

        // Zero amount: done two edges after start, no request.
        run_pay(7'd0, 4'b0000, 2, 20, 0);
        check("p0_done_cyc", done_cyc, 1);
        check("p0_req", req_total, 0);
        check("p0_busy", int'(busy_cyc <= 1), 1);
        check("p0_paid", coins_paid, 0);
        tick();
        check("p0_done_pulse", done, 0);

        // 20-coin tube empty: 40 = 4 x 10.
        run_pay(7'd40, 4'b1000, 2, 200, 0);
        exp_q = '{2, 2, 2, 2};
        check_seq("p40_sel", exp_q);
        check("p40_done", n_done, 1);
        check("p40_gap", gap_bad, 0);
        check("p40_paid", coins_paid, 4);
        tick();

        // 3 with 1-coin tube empty: nothing fits.
        run_pay(7'd3, 4'b0001, 2, 20, 0);
        check("p3_fault", fault, 1);
        check("p3_req", req_total, 0);
        check("p3_rem", remaining, 3);
        check("p3_busy", busy, 0);
        amount = 7'd5;
        empty  = 4'b0000;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        check("p3_start_ign", busy, 0);
        check("p3_rem_frozen", remaining, 3);
        check("p3_req_ign", coin_req, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("p3_clear", fault, 0);
        check("p3_idle_busy", busy, 0);
        tick();

        // Hopper never acks: timeout after 255 request cycles.
        run_pay(7'd5, 4'b0000, -1, 400, 0);
        check("tmo_req_cyc", req_total, 255);
        check("tmo_fault", fault, 1);
        check("tmo_rem", remaining, 5);
        check("tmo_paid", coins_paid, 0);
        check("tmo_req_low", coin_req, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("tmo_clear", fault, 0);
        tick();

        // Reset during the second request of a 25 payout.
        run_pay(7'd25, 4'b0000, 2, 200, 2);
        check("r25_sel1", coin_sel, 1);
        check("r25_rem", remaining, 5);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("r25_req", coin_req, 0);
        check("r25_sel", coin_sel, 0);
        check("r25_busy", busy, 0);
        check("r25_done", done, 0);
        check("r25_fault", fault, 0);
        check("r25_rem0", remaining, 0);
        check("r25_paid", coins_paid, 0);
        tick();

        run_pay(7'd7, 4'b0000, 2, 200, 0);
        exp_q = '{1, 0, 0};
        check_seq("p7_sel", exp_q);
        check("p7_done", n_done, 1);
        check("p7_paid", coins_paid, 3);
        check("p7_rem", remaining, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
